mac_row4: RTL and testbench
===========================

Name: mac_row4

Overview:
- Four-tap half-precision (IEEE-754 binary16) multiply-accumulate row.
- Holds four weights W[0..3], loaded by one-hot write enables.
- Streams activations X_i; every 4 accepted activations form one vector and produce Y = X0·W[0] + X1·W[1] + X2·W[2] + X3·W[3].
- Used as one row of a small FP16 matrix-vector engine.

Parameters:
- NTAP, 4, number of weights per row / activations per vector (only 4 required).
- DW, 16, data width (binary16: sign[15], exp[14:10] bias 15, mant[9:0]).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-high reset; the port name is kept per codebase convention, and the polarity is active-high.
- enX  input  1  X_i valid this cycle.
- enW  input  4  one-hot weight write enable; bit k writes W[k].
- X_i  input  16  FP16 activation.
- W_i  input  16  FP16 weight data.
- valid_o  output  1  one-cycle pulse when Y_o is updated.
- Y_o  output  16  FP16 dot-product result.

Behaviour:
- Reset (async, active-high):
  - W[0..3] = 0x0000, tap counter = 0, accumulator = +0.
  - Y_o = 0x0000, valid_o = 0.
- Weight write:
  - On a clk edge, for each enW[k]=1, W[k] <= W_i.
  - Multiple bits set writes all selected weights.
  - A write takes effect the next cycle; a same-cycle X uses the old weight.
- Activation accept:
  - On each edge with enX=1, X_i is paired with W[cnt].
  - The product is added to the accumulator, then cnt increments modulo 4.
  - enX=0 holds cnt and the accumulator; gaps inside a vector are legal.
- Accumulation order: acc = ((((+0 + p0) + p1) + p2) + p3). Each multiply and add is rounded separately, with no fused operation.
- Completion:
  - On the edge accepting the cnt=3 activation, Y_o <= acc + p3 and valid_o <= 1 for exactly one cycle.
  - Latency: valid_o is high in the cycle following the 4th accepted X.
  - The accumulator clears to +0 on that same edge, so back-to-back vectors need no idle cycle.
  - Y_o holds its value until the next completion.
- Arithmetic:
  - Full subnormal support on inputs and results.
  - Rounding is round-toward-zero (truncate).
  - Sign of a product is XOR of the operand signs.
  - x + (-x) = +0.
  - Overflow gives ±Inf (0x7C00/0xFC00).
  - Underflow below the minimum subnormal gives ±0.
- Specials:
  - Inf·finite nonzero = ±Inf.
  - Inf·0, Inf + (-Inf), or any NaN operand gives canonical NaN 0x7E00.
- Reset mid-vector discards partial sums and restarts at cnt=0.

Optional Feature:
- MACROW4_RNE_EN:
  - When defined, multiplier and adder round to nearest, ties to even; overflow after rounding gives ±Inf.
  - When undefined, round-toward-zero as specified above.
  - Exactly representable results are identical in both modes.

Decomposition:
- Package fp16_pkg holds:
  - field widths (EXP_W=5, MAN_W=10) and BIAS=15;
  - constants POS_INF 16'h7C00, NEG_INF 16'hFC00, QNAN 16'h7E00;
  - an unpacked-fields struct {sign, exp, mant} for FP16.
- Sub-module fp16_add (combinational FP16 adder): used for the accumulate step.
- The FP16 multiply is implemented inline in mac_row4.

Test Plan:
- Weights W=0x3C00 (1.0) ×4; X = 0x3C00, 0x4000, 0x4200, 0x4400 (1, 2, 3, 4) -> valid_o pulse one cycle after 4th X, Y_o=0x4900 (10.0).
- W = 0xBC00 (-1.0) ×4; X = 0x3C00 ×4, then immediately X = 0x3800 ×4 -> two pulses 4 cycles apart, Y_o=0xC400 (-4.0), then 0xC000 (-2.0).
- W = 0x0001 (min subnormal) ×4; X = 0x3C00 ×4 -> Y_o=0x0004.
- W[0]=0x7BFF, others 0; X[0]=0x7BFF, others 0x3C00 -> Y_o=0x7C00 (+Inf). W[0]=0x7C00 with X[0]=0x0000 -> Y_o=0x7E00.
- W=0x4000 ×4; send 2 X of 0x3C00, deassert enX 3 cycles, send 2 more -> single pulse, Y_o=0x4800 (8.0). Repeat, pulsing reset after 2 X, then 4 X of 0x3800 -> Y_o=0x4400; Y_o=0 and valid_o=0 during reset.
- Write W[2] with enW=4'b0100 on the same edge as its paired X -> old W[2] used; the next vector uses the new W[2].

Source files
------------

// File: rtl/fp16_pkg.sv
// FP16 field layout, special encodings and the shared normalise/round/pack step.
// Define MACROW4_RNE_EN for round-to-nearest-even; the default build truncates.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;
    localparam int MAG_W = 42;

    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;
    localparam logic [15:0] QNAN    = 16'h7E00;

`ifdef MACROW4_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp16_t;

    // Rounds the exact finite value mag * 2^scale to FP16 with a single rounding.
    function automatic logic [15:0] round_pack(input logic sign, input int scale,
                                               input logic [MAG_W-1:0] mag);
        int               lead;
        int               f;
        int               sh;
        logic [MAG_W-1:0] norm;
        logic [13:0]      sig;
        logic [27:0]      ext;
        logic [11:0]      rnd;
        logic             up;
        logic [15:0]      res;
        lead = 0;
        for (int i = 0; i < MAG_W; i++)
            if (mag[i]) lead = i;
        norm = mag << (MAG_W - 1 - lead);
        // 11 significand bits, then guard, round and sticky
        sig  = {norm[MAG_W-1 -: 13], |norm[MAG_W-14:0]};
        f    = lead + scale + BIAS;
        sh   = (f < 1) ? 1 - f : 0;
        if (sh > 15) sh = 15;
        if (f < 1) f = 0;
        ext  = {sig, 14'b0} >> sh;
        sig  = {ext[27:15], ext[14] | (|ext[13:0])};
        up   = RNE & sig[2] & (sig[3] | sig[1] | sig[0]);
        rnd  = {1'b0, sig[13:3]} + {11'b0, up};
        if (rnd[11]) begin
            rnd = rnd >> 1;
            f   = f + 1;
        end
        // A subnormal that rounds up into the hidden bit becomes the smallest normal
        if (f == 0 && rnd[10]) f = 1;
        if (mag == '0)
            res = {sign, 15'b0};
        else if (f >= 31)
            res = sign ? NEG_INF : POS_INF;
        else
            res = {sign, f[4:0], rnd[9:0]};
        return res;
    endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: exact aligned sum, then one rounding via round_pack.
module fp16_add
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    localparam int ALIGN = MAG_W - MAN_W - 3;

    fp16_t            fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf;
    logic             a_big, eff_sub, sign_r, sign_big;
    logic [MAN_W:0]   sig_a, sig_b, sig_big, sig_small;
    int               e_a, e_b, e_big, e_small;
    logic [MAG_W-1:0] mag_big, mag_small, sum;

    // NOTE: every variable here is assigned on every path through the block,
    // so no storage (latch) is inferred.
    always_comb begin
        fa        = fp16_t'(a);
        fb        = fp16_t'(b);
        a_nan     = (fa.exp == '1) && (fa.mant != '0);
        b_nan     = (fb.exp == '1) && (fb.mant != '0);
        a_inf     = (fa.exp == '1) && (fa.mant == '0);
        b_inf     = (fb.exp == '1) && (fb.mant == '0);
        sig_a     = {|fa.exp, fa.mant};
        sig_b     = {|fb.exp, fb.mant};
        e_a       = (fa.exp == '0) ? 1 : int'(fa.exp);
        e_b       = (fb.exp == '0) ? 1 : int'(fb.exp);
        a_big     = {fa.exp, fa.mant} >= {fb.exp, fb.mant};
        sig_big   = a_big ? sig_a : sig_b;
        sig_small = a_big ? sig_b : sig_a;
        e_big     = a_big ? e_a : e_b;
        e_small   = a_big ? e_b : e_a;
        sign_big  = a_big ? fa.sign : fb.sign;
        // Alignment shift is at most 29, so the smaller operand loses no bits
        mag_big   = {2'b0, sig_big, {ALIGN{1'b0}}};
        mag_small = {2'b0, sig_small, {ALIGN{1'b0}}} >> (e_big - e_small);
        eff_sub   = fa.sign ^ fb.sign;
        sum       = eff_sub ? (mag_big - mag_small) : (mag_big + mag_small);
        sign_r    = (sum == '0) ? (fa.sign & fb.sign) : sign_big;

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
            y = QNAN;
        else if (a_inf)
            y = a;
        else if (b_inf)
            y = b;
        else
            y = round_pack(sign_r, e_big - BIAS - MAN_W - ALIGN, sum);
    end

endmodule

// File: rtl/mac_row4.sv
// Four-tap FP16 multiply-accumulate row: Y = sum X_k * W[k], one result per 4 activations.
// Rounding mode follows MACROW4_RNE_EN (see fp16_pkg).
module mac_row4
    import fp16_pkg::*;
#(
    parameter int NTAP = 4,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enX,
    input  logic [NTAP-1:0] enW,
    input  logic [DW-1:0]   X_i,
    input  logic [DW-1:0]   W_i,
    output logic            valid_o,
    output logic [DW-1:0]   Y_o
);

    localparam int CW = $clog2(NTAP);

    logic [DW-1:0]    w [NTAP];
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    prod;
    logic [DW-1:0]    sum;
    fp16_t            fx, fw;
    logic             x_nan, w_nan, x_inf, w_inf, x_zero, w_zero, p_sign;
    logic [2*MAN_W+1:0] p_mag;
    int               e_x, e_w;

    always_comb begin
        fx     = fp16_t'(X_i);
        fw     = fp16_t'(w[cnt]);
        x_nan  = (fx.exp == '1) && (fx.mant != '0);
        w_nan  = (fw.exp == '1) && (fw.mant != '0);
        x_inf  = (fx.exp == '1) && (fx.mant == '0);
        w_inf  = (fw.exp == '1) && (fw.mant == '0);
        x_zero = (fx.exp == '0) && (fx.mant == '0);
        w_zero = (fw.exp == '0) && (fw.mant == '0);
        p_sign = fx.sign ^ fw.sign;
        e_x    = (fx.exp == '0) ? 1 : int'(fx.exp);
        e_w    = (fw.exp == '0) ? 1 : int'(fw.exp);
        p_mag  = {{(MAN_W+1){1'b0}}, |fx.exp, fx.mant} * {{(MAN_W+1){1'b0}}, |fw.exp, fw.mant};

        if (x_nan || w_nan || (x_inf && w_zero) || (w_inf && x_zero))
            prod = QNAN;
        else if (x_inf || w_inf)
            prod = p_sign ? NEG_INF : POS_INF;
        else
            prod = round_pack(p_sign, e_x + e_w - 2 * (BIAS + MAN_W),
                              {{(MAG_W-2*MAN_W-2){1'b0}}, p_mag});
    end

    fp16_add u_add (
        .a (acc),
        .b (prod),
        .y (sum)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // this is what makes a same-edge weight write invisible to the paired X.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            // NOTE: the weights are a small register file, not RAM, so they take
            // the async reset like any other state.
            for (int k = 0; k < NTAP; k++)
                w[k] <= '0;
            cnt     <= '0;
            acc     <= '0;
            Y_o     <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            for (int k = 0; k < NTAP; k++)
                if (enW[k]) w[k] <= W_i;
            if (enX) begin
                if (cnt == CW'(NTAP - 1)) begin
                    Y_o     <= sum;
                    valid_o <= 1'b1;
                    acc     <= '0;
                end else begin
                    acc <= sum;
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_row4.sv
// Self-checking bench for mac_row4: directed plan vectors plus random stimulus
// against a real-arithmetic reference model of the dot product.
module tb_mac_row4;

`ifdef MACROW4_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enX;
    logic [3:0]  enW;
    logic [15:0] X_i;
    logic [15:0] W_i;
    logic        valid_o;
    logic [15:0] Y_o;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] m_w [4];
    logic [15:0] px  [4];
    logic [15:0] pw  [4];
    int          m_cnt;
    logic [15:0] m_y;
    logic        m_valid;

    mac_row4 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enX     (enX),
        .enW     (enW),
        .X_i     (X_i),
        .W_i     (W_i),
        .valid_o (valid_o),
        .Y_o     (Y_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expd);
        n_checks++;
        assert (obs === expd)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expd);
        end
    endtask

    // ---------------- reference model (exact reals, one rounding per op) ----
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real mag_of(input logic [15:0] h);
        int ex = int'(h[14:10]);
        int mn = int'(h[9:0]);
        if (ex == 0) return $itor(mn) * pow2(-24);
        return $itor(1024 + mn) * pow2(ex - 25);
    endfunction

    function automatic bit is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] != 10'h0);
    endfunction

    function automatic bit is_inf(input logic [15:0] h);
        return (h[14:10] == 5'h1F) && (h[9:0] == 10'h0);
    endfunction

    function automatic logic [15:0] to_fp16(input bit s, input real mag);
        int  e;
        int  n;
        real q;
        real rem;
        if (mag == 0.0) return {s, 15'h0};
        e = 0;
        while (mag >= pow2(e + 1)) e++;
        while (mag < pow2(e)) e--;
        if (e < -14) e = -14;
        q   = mag / pow2(e - 10);
        n   = $rtoi(q);
        rem = q - $itor(n);
        if (RNE && (rem > 0.5 || (rem == 0.5 && (n % 2) == 1))) n++;
        if (n == 2048) begin
            n = 1024;
            e++;
        end
        if (e > 15) return s ? 16'hFC00 : 16'h7C00;
        if (n < 1024) return {s, 5'd0, 10'(n)};
        return {s, 5'(e + 15), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        bit s = a[15] ^ b[15];
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if ((is_inf(a) && mag_of(b) == 0.0) || (is_inf(b) && mag_of(a) == 0.0)) return 16'h7E00;
        if (is_inf(a) || is_inf(b)) return s ? 16'hFC00 : 16'h7C00;
        return to_fp16(s, mag_of(a) * mag_of(b));
    endfunction

    function automatic logic [15:0] add_ref(input logic [15:0] a, input logic [15:0] b);
        real va;
        real vb;
        real r;
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return 16'h7E00;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        va = a[15] ? -mag_of(a) : mag_of(a);
        vb = b[15] ? -mag_of(b) : mag_of(b);
        r  = va + vb;
        if (r == 0.0) return {a[15] & b[15], 15'h0};
        return (r < 0.0) ? to_fp16(1'b1, -r) : to_fp16(1'b0, r);
    endfunction

    // ---------------- stimulus helpers ---------------------------------------
    task automatic cycle(input bit ex, input logic [3:0] ew, input logic [15:0] x,
                         input logic [15:0] w);
        logic [15:0] acc;
        enX = ex;
        enW = ew;
        X_i = x;
        W_i = w;
        m_valid = 1'b0;
        if (ex) begin
            px[m_cnt] = x;
            pw[m_cnt] = m_w[m_cnt];
            m_cnt++;
            if (m_cnt == 4) begin
                acc = 16'h0000;
                for (int i = 0; i < 4; i++) acc = add_ref(acc, mul_ref(px[i], pw[i]));
                m_y     = acc;
                m_valid = 1'b1;
                m_cnt   = 0;
            end
        end
        for (int k = 0; k < 4; k++) if (ew[k]) m_w[k] = w;
        @(posedge clk);
        @(negedge clk);
        check("valid_o", {15'h0, valid_o}, {15'h0, m_valid});
        check("Y_o", Y_o, m_y);
    endtask

    task automatic xin(input logic [15:0] x);
        cycle(1'b1, 4'b0000, x, 16'h0000);
    endtask

    task automatic wall(input logic [3:0] ew, input logic [15:0] w);
        cycle(1'b0, ew, 16'h0000, w);
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        enX     = 1'b0;
        enW     = 4'b0000;
        m_cnt   = 0;
        m_y     = 16'h0000;
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) m_w[k] = 16'h0000;
        #1;
        check("reset_valid", {15'h0, valid_o}, 16'h0000);
        check("reset_Y", Y_o, 16'h0000);
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    function automatic logic [15:0] rand_fp16();
        logic [15:0] v;
        case ($urandom_range(0, 19))
            0, 1:    v = 16'($urandom);
            2, 3:    v = {1'($urandom), 5'd0, 10'($urandom)};
            4: begin
                case ($urandom_range(0, 5))
                    0:       v = 16'h0000;
                    1:       v = 16'h8000;
                    2:       v = 16'h7C00;
                    3:       v = 16'hFC00;
                    4:       v = 16'h7E00;
                    default: v = 16'h7BFF;
                endcase
            end
            default: v = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        reset_n = 1'b0;
        enX     = 1'b0;
        enW     = 4'b0000;
        X_i     = 16'h0000;
        W_i     = 16'h0000;
        #2;
        do_reset();

        // 1+2+3+4 with unit weights
        wall(4'b1111, 16'h3C00);
        xin(16'h3C00); xin(16'h4000); xin(16'h4200); xin(16'h4400);
        check("sum_10", Y_o, 16'h4900);

        // back-to-back vectors with negative weights
        wall(4'b1111, 16'hBC00);
        for (int i = 0; i < 4; i++) xin(16'h3C00);
        check("neg_4", Y_o, 16'hC400);
        for (int i = 0; i < 4; i++) xin(16'h3800);
        check("neg_2", Y_o, 16'hC000);

        // minimum subnormal weights
        wall(4'b1111, 16'h0001);
        for (int i = 0; i < 4; i++) xin(16'h3C00);
        check("subnorm_4", Y_o, 16'h0004);

        // overflow to +Inf, then Inf*0 to NaN
        wall(4'b0001, 16'h7BFF);
        wall(4'b1110, 16'h0000);
        xin(16'h7BFF); xin(16'h3C00); xin(16'h3C00); xin(16'h3C00);
        check("ovf_inf", Y_o, 16'h7C00);
        wall(4'b0001, 16'h7C00);
        xin(16'h0000); xin(16'h3C00); xin(16'h3C00); xin(16'h3C00);
        check("inf_x_zero", Y_o, 16'h7E00);

        // gaps inside a vector
        wall(4'b1111, 16'h4000);
        xin(16'h3C00); xin(16'h3C00);
        for (int i = 0; i < 3; i++) wall(4'b0000, 16'h0000);
        xin(16'h3C00); xin(16'h3C00);
        check("gap_8", Y_o, 16'h4800);

        // reset mid-vector discards the partial sum and the weights
        xin(16'h3C00); xin(16'h3C00);
        do_reset();
        wall(4'b1111, 16'h4000);
        for (int i = 0; i < 4; i++) xin(16'h3800);
        check("post_reset_4", Y_o, 16'h4400);

        // weight write on the same edge as its paired X
        wall(4'b1111, 16'h3C00);
        xin(16'h3C00); xin(16'h3C00);
        cycle(1'b1, 4'b0100, 16'h4000, 16'h4200);
        xin(16'h3C00);
        check("same_edge_old_w", Y_o, 16'h4500);
        xin(16'h3C00); xin(16'h3C00); xin(16'h4000); xin(16'h3C00);
        check("next_vec_new_w", Y_o, 16'h4880);

        // random traffic: gaps, weight rewrites, specials and subnormals
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  rand_fp16(), rand_fp16());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
